// File: rtl/hazard_forward_ctrl.sv
// Purpose: EX-stage forwarding selects and load-use stall request, driven from a shadow EX/MEM/WB pipeline of register-write metadata.
// Latency: ForwardA/ForwardB/Stall are combinational (same cycle); the shadow pipeline and StallCount update on each rising clk edge.
// Backpressure: Stall holds PC and IF/ID for one cycle while a bubble enters EX; Flush squashes the ID instruction and suppresses Stall.
//
// Ports:
//   clk, rst                  pipeline clock, asynchronous active-high reset
//   ID_Valid/Rs/Rt/UsesRt     decode-stage instruction and its sources
//   ID_RegWrite/ID_MemRead    decode-stage write / load flags
//   Flush                     squash the ID instruction
//   EX_DestReg                resolved destination of the EX instruction
//   ForwardA/ForwardB         operand selects: 00 regfile, 10 MEM ALU result, 01 WB write data
//   Stall                     load-use hazard stall request
//   StallCount                saturating count of stall cycles

`timescale 1ns/1ps

module hazard_forward_ctrl #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ID_Valid,
  input  logic [REG_BITS-1:0] ID_Rs,
  input  logic [REG_BITS-1:0] ID_Rt,
  input  logic                ID_UsesRt,
  input  logic                ID_RegWrite,
  input  logic                ID_MemRead,
  input  logic                Flush,
  input  logic [REG_BITS-1:0] EX_DestReg,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                Stall,
  output logic [CNT_BITS-1:0] StallCount
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  // EX slot
  logic                ex_vld_q, ex_vld_d;
  logic [REG_BITS-1:0] ex_rs_q, ex_rs_d;
  logic [REG_BITS-1:0] ex_rt_q, ex_rt_d;
  logic                ex_regwrite_q, ex_regwrite_d;
  logic                ex_memread_q, ex_memread_d;
  // MEM slot
  logic                mem_vld_q, mem_vld_d;
  logic [REG_BITS-1:0] mem_dest_q, mem_dest_d;
  logic                mem_regwrite_q, mem_regwrite_d;
  logic                mem_memread_q, mem_memread_d;
  // WB slot
  logic                wb_vld_q, wb_vld_d;
  logic [REG_BITS-1:0] wb_dest_q, wb_dest_d;
  logic                wb_regwrite_q, wb_regwrite_d;
  // stall performance counter
  logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_fwd_ok;
  logic wb_writer;
  logic load_in_ex;
  logic src_hit;
  logic stall;

  // A load's data is not available in MEM yet, so only ALU results forward from there.
  assign mem_fwd_ok = mem_vld_q & mem_regwrite_q & (mem_dest_q != '0) & ~mem_memread_q;
  assign wb_writer  = wb_vld_q & wb_regwrite_q & (wb_dest_q != '0);

  function automatic logic [1:0] fwd_sel(
    input logic                ex_vld,
    input logic [REG_BITS-1:0] src,
    input logic                mem_ok,
    input logic [REG_BITS-1:0] mem_dest,
    input logic                wb_ok,
    input logic [REG_BITS-1:0] wb_dest
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    // R0 reads are constant zero; bubbles need no operand.
    if (ex_vld && (src != '0)) begin
      if (mem_ok && (mem_dest == src)) begin
        sel = FWD_MEM;          // youngest producer wins
      end else if (wb_ok && (wb_dest == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  assign ForwardA = fwd_sel(ex_vld_q, ex_rs_q, mem_fwd_ok, mem_dest_q, wb_writer, wb_dest_q);
  assign ForwardB = fwd_sel(ex_vld_q, ex_rt_q, mem_fwd_ok, mem_dest_q, wb_writer, wb_dest_q);

  // Load-use: the EX load's data only exists after MEM, so a dependent ID
  // instruction waits one cycle and then picks the value up from WB.
  assign load_in_ex = ex_vld_q & ex_memread_q & ex_regwrite_q & (EX_DestReg != '0);
  assign src_hit    = (EX_DestReg == ID_Rs) | (ID_UsesRt & (EX_DestReg == ID_Rt));
  // A squashed ID instruction cannot create a hazard.
  assign stall      = load_in_ex & ID_Valid & src_hit & ~Flush;
  assign Stall      = stall;

  assign StallCount = stall_cnt_q;

  always_comb begin
    // MEM -> WB
    wb_vld_d       = mem_vld_q;
    wb_dest_d      = mem_dest_q;
    wb_regwrite_d  = mem_regwrite_q;
    // EX -> MEM; destination comes from the resolved EX_DestReg
    mem_vld_d      = ex_vld_q;
    mem_dest_d     = EX_DestReg;
    mem_regwrite_d = ex_regwrite_q;
    mem_memread_d  = ex_memread_q;
    // ID -> EX, or a bubble on stall/flush
    if (stall || Flush) begin
      ex_vld_d      = 1'b0;
      ex_rs_d       = '0;
      ex_rt_d       = '0;
      ex_regwrite_d = 1'b0;
      ex_memread_d  = 1'b0;
    end else begin
      ex_vld_d      = ID_Valid;
      ex_rs_d       = ID_Rs;
      ex_rt_d       = ID_Rt;
      ex_regwrite_d = ID_RegWrite;
      ex_memread_d  = ID_MemRead;
    end
    // saturating stall counter
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_vld_q       <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_vld_q      <= 1'b0;
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_vld_q       <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_vld_q       <= ex_vld_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_vld_q      <= mem_vld_d;
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      wb_vld_q       <= wb_vld_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: a directed instruction stream is issued through
// an instruction-level pipeline model (history of what entered EX each cycle);
// outputs are compared every cycle, plus literal per-instruction expectations.

`timescale 1ns/1ps

module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic       vld;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] dest;
    logic       ut;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       chk_f;    // literal forward expectation when in EX
    logic [1:0] efa;
    logic [1:0] efb;
    logic       chk_s;    // literal stall expectation on first ID cycle
    logic       es;
    logic       rst_mid;  // pulse reset during this instruction's first ID cycle
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid;
  logic [2:0]  ID_Rs;
  logic [2:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        Flush;
  logic [2:0]  EX_DestReg;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        Stall;
  logic [15:0] StallCount;

  hazard_forward_ctrl #(.REG_BITS(3), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .Flush(Flush),
    .EX_DestReg(EX_DestReg),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  instr_t prog[$];
  instr_t issued[$];   // [0] = instruction in EX, [1] one older, [2] two older
  int     cnt_m;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic add(input int vld, input int rs, input int rt, input int ut,
                     input int rw, input int mr, input int dest, input int fl,
                     input int chkf, input int efa, input int efb,
                     input int chks, input int es, input int rm);
    instr_t t;
    t.vld = vld[0]; t.rs = rs[2:0]; t.rt = rt[2:0]; t.ut = ut[0];
    t.rw = rw[0]; t.mr = mr[0]; t.dest = dest[2:0]; t.fl = fl[0];
    t.chk_f = chkf[0]; t.efa = efa[1:0]; t.efb = efb[1:0];
    t.chk_s = chks[0]; t.es = es[0]; t.rst_mid = rm[0];
    prog.push_back(t);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    issued.delete();
    for (int i = 0; i < 3; i++) issued.push_back('0);
    cnt_m = 0;
  endtask

  function automatic logic writes(input instr_t p);
    return p.vld && p.rw && (p.dest != 3'd0);
  endfunction

  // Producer one instruction ahead (non-load) beats producer two ahead.
  function automatic logic [1:0] m_fwd(input logic [2:0] src);
    if (!issued[0].vld || src == 3'd0) return 2'b00;
    if (writes(issued[1]) && !issued[1].mr && issued[1].dest == src) return 2'b10;
    if (writes(issued[2]) && issued[2].dest == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall(input instr_t id);
    instr_t ex;
    ex = issued[0];
    if (id.fl || !id.vld) return 1'b0;
    if (!(writes(ex) && ex.mr)) return 1'b0;
    return (ex.dest == id.rs) || (id.ut && ex.dest == id.rt);
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_fwd_a"}, ForwardA, 0);
    chk({tag, "_fwd_b"}, ForwardB, 0);
    chk({tag, "_stall"}, Stall, 0);
    chk({tag, "_count"}, StallCount, 0);
  endtask

  initial begin
    instr_t id;
    int     pc;
    logic   fresh;
    logic   s;

    //    vld rs rt ut rw mr de fl chkf efa efb chks es rm
    add(1, 1, 2, 1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0); // I0  R3 <- R1,R2
    add(1, 3, 4, 1, 1, 0, 6, 0, 1, 2, 0, 0, 0, 0); // I1  reads R3, 1 apart -> 10
    add(1, 3, 0, 0, 1, 0, 7, 0, 1, 1, 0, 0, 0, 0); // I2  reads R3, 2 apart -> 01
    add(1, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // I3  reads R3, 3 apart -> 00
    add(1, 0, 0, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0); // I4  R5 writer
    add(1, 1, 1, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0); // I5  R5 writer
    add(1, 2, 5, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0); // I6  Rt=R5, MEM+WB match -> 10
    add(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // I7  writes R0
    add(1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0); // I8  reads R0 -> 00
    add(1, 2, 2, 1, 0, 0, 4, 0, 1, 0, 0, 0, 0, 0); // I9  RegWrite=0 "to" R4
    add(1, 4, 4, 1, 1, 0, 6, 0, 1, 0, 0, 0, 0, 0); // I10 reads R4 -> 00
    add(1, 4, 4, 1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0); // I11 reads R4 -> 00
    add(1, 1, 0, 0, 1, 1, 2, 0, 1, 0, 0, 1, 0, 0); // I12 load R2
    add(1, 6, 2, 1, 1, 0, 7, 0, 1, 0, 1, 1, 1, 0); // I13 Rt=R2 -> stall, then 01
    add(1, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 1, 0, 0); // I14 load R2
    add(1, 1, 2, 0, 1, 0, 4, 0, 1, 0, 0, 1, 0, 0); // I15 Rt=R2 unused -> no stall
    add(1, 0, 0, 0, 1, 1, 5, 0, 1, 0, 0, 1, 0, 0); // I16 load R5
    add(1, 5, 0, 0, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0); // I17 flushed reader of R5
    add(1, 5, 5, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0); // I18 sees load in WB -> 01/01
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // I19 idle
    add(1, 0, 0, 0, 1, 1, 4, 0, 1, 0, 0, 1, 0, 0); // I20 load R4
    add(1, 4, 0, 0, 1, 0, 2, 0, 1, 0, 0, 1, 1, 1); // I21 stall, reset mid-stall
    add(1, 2, 2, 1, 0, 0, 0, 0, 1, 2, 2, 1, 0, 0); // I22 reads R2 from I21 -> 10/10

    model_reset();
    rst = 1'b1;
    ID_Valid = 1'b0; ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0;
    ID_RegWrite = 1'b0; ID_MemRead = 1'b0; Flush = 1'b0; EX_DestReg = '0;
    #1;
    reset_checks("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    pc = 0;
    fresh = 1'b1;
    for (int cyc = 0; cyc < 400 && pc < prog.size() + 3; cyc++) begin
      id = (pc < prog.size()) ? prog[pc] : instr_t'('0);
      ID_Valid = id.vld; ID_Rs = id.rs; ID_Rt = id.rt; ID_UsesRt = id.ut;
      ID_RegWrite = id.rw; ID_MemRead = id.mr; Flush = id.fl;
      EX_DestReg = issued[0].dest;

      @(negedge clk);
      chk("model_fwd_a", ForwardA, m_fwd(issued[0].rs));
      chk("model_fwd_b", ForwardB, m_fwd(issued[0].rt));
      chk("model_stall", Stall, m_stall(id));
      chk("model_count", StallCount, cnt_m);
      if (issued[0].chk_f) begin
        chk("lit_fwd_a", ForwardA, issued[0].efa);
        chk("lit_fwd_b", ForwardB, issued[0].efb);
      end
      if (fresh && id.chk_s) chk("lit_stall", Stall, id.es);
      if (fresh && id.rst_mid) begin
        chk("lit_count_pre_reset", StallCount, 1);
        #1 rst = 1'b1;
        #1;
        reset_checks("mid_reset");
        model_reset();
        EX_DestReg = issued[0].dest;
        #1 rst = 1'b0;
      end

      @(posedge clk);
      s = m_stall(id);
      if (s) begin
        if (cnt_m < 65535) cnt_m++;
        issued.push_front('0);
        fresh = 1'b0;
      end else begin
        issued.push_front(id.fl ? instr_t'('0) : id);
        pc++;
        fresh = 1'b1;
      end
      void'(issued.pop_back());
      #1;
    end

    if (pc < prog.size() + 3) chk("stream_completed", pc, prog.size() + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
